// File: rtl/tone_period_meter.sv
// Measures the period of an incoming square-wave tone in clk cycles, classifies it
// against the equal-tempered notes C4..B4 and flags silence.
module tone_period_meter #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int CNT_W       = 22,
  parameter int TIMEOUT_CYC = 2_500_000,
  parameter int MIN_PER     = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tone_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic [3:0]       note_idx,
  output logic             note_hit,
  output logic             stable,
  output logic             silent
);

  typedef enum logic [1:0] {IDLE, MEASURE, CLASSIFY} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] MIN_V     = CNT_W'(MIN_PER);
  localparam logic [3:0]       NO_NOTE   = 4'd15;

  // Reference periods are given at 50 MHz and rescaled (rounded) to the actual clock.
  function automatic logic [CNT_W-1:0] note_period(input int n);
    longint unsigned base;
    case (n)
      0:       base = 64'd191112;
      1:       base = 64'd180388;
      2:       base = 64'd170265;
      3:       base = 64'd160705;
      4:       base = 64'd151685;
      5:       base = 64'd143172;
      6:       base = 64'd135139;
      7:       base = 64'd127551;
      8:       base = 64'd120395;
      9:       base = 64'd113636;
      10:      base = 64'd107259;
      default: base = 64'd101239;
    endcase
    return CNT_W'((base * 64'(CLK_HZ) + 64'd25_000_000) / 64'd50_000_000);
  endfunction

  function automatic logic [CNT_W-1:0] abs_diff(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  localparam logic [CNT_W-1:0] NOTE_P [12] = '{
    note_period(0), note_period(1), note_period(2),  note_period(3),
    note_period(4), note_period(5), note_period(6),  note_period(7),
    note_period(8), note_period(9), note_period(10), note_period(11)
  };

  state_t           state;
  logic             sync1, sync2, sync2_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] prev;
  logic             prev_ok;
  logic [3:0]       idx;
  logic [CNT_W-1:0] p_sel;
  logic             rise, accept, timeout, hit;

  assign rise    = sync2 & ~sync2_d;
  // Short intervals are glitches; in IDLE any edge is a valid reference.
  assign accept  = rise & ((state == IDLE) | (cnt >= MIN_V));
  assign timeout = (state != IDLE) && (cnt >= TIMEOUT_V);

  always_comb begin
    p_sel = '0;
    if (idx <= 4'd11) p_sel = NOTE_P[idx];
  end

  assign hit = abs_diff(period, p_sel) <= (p_sel >> 6);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1        <= 1'b0;
      sync2        <= 1'b0;
      sync2_d      <= 1'b0;
      cnt          <= '0;
      state        <= IDLE;
      idx          <= 4'd0;
      prev         <= '0;
      prev_ok      <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      note_idx     <= NO_NOTE;
      note_hit     <= 1'b0;
      stable       <= 1'b0;
      silent       <= 1'b1;
    end else begin
      sync1        <= tone_in;
      sync2        <= sync1;
      sync2_d      <= sync2;
      period_valid <= 1'b0;

      if (accept)              cnt <= CNT_W'(1);
      else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;

      if (timeout) begin
        silent   <= 1'b1;
        note_hit <= 1'b0;
        note_idx <= NO_NOTE;
        stable   <= 1'b0;
        prev_ok  <= 1'b0;
        state    <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (accept) state <= MEASURE;
          end
          MEASURE: begin
            if (accept) begin
              period       <= cnt;
              period_valid <= 1'b1;
              silent       <= 1'b0;
              stable       <= prev_ok & (abs_diff(cnt, prev) <= (cnt >> 6));
              prev         <= cnt;
              prev_ok      <= 1'b1;
              idx          <= 4'd0;
              state        <= CLASSIFY;
            end
          end
          CLASSIFY: begin
            // One table entry per cycle; the first entry within tolerance wins.
            if (hit) begin
              note_idx <= idx;
              note_hit <= 1'b1;
              state    <= MEASURE;
            end else if (idx == 4'd11) begin
              note_idx <= NO_NOTE;
              note_hit <= 1'b0;
              state    <= MEASURE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tone_period_meter.sv
// Directed bench for tone_period_meter at a scaled-down clock (500 kHz table, 4000-cycle
// timeout); expected periods/notes are queued when edges are driven and checked on output.
module tb_tone_period_meter;

  localparam int CLK_HZ  = 500_000;
  localparam int CNT_W   = 22;
  localparam int TIMEOUT = 4000;
  localparam int P_A4    = 1137;
  localparam int P_B4    = 1012;
  localparam int P_LOW   = 3000;

  logic             clk;
  logic             reset;
  logic             tone_in;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic [3:0]       note_idx;
  logic             note_hit;
  logic             stable;
  logic             silent;

  tone_period_meter #(
    .CLK_HZ(CLK_HZ), .CNT_W(CNT_W), .TIMEOUT_CYC(TIMEOUT), .MIN_PER(64)
  ) dut (
    .clk(clk), .reset(reset), .tone_in(tone_in), .period(period),
    .period_valid(period_valid), .note_idx(note_idx), .note_hit(note_hit),
    .stable(stable), .silent(silent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int per;
    bit stb;
    int idx;
    bit hit;
  } exp_t;

  exp_t exp_q[$];
  int   checks_total  = 0;
  int   checks_passed = 0;
  int   checks_failed = 0;

  // Note periods at 500 kHz: 50 MHz table divided by 100, rounded.
  int note_tab [12] = '{1911, 1804, 1703, 1607, 1517, 1432, 1351, 1276, 1204, 1136, 1073, 1012};

  bit ref_ok   = 0;
  int gap      = 0;
  bit mprev_ok = 0;
  int mprev    = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks_total++;
    assert (obs === expv) checks_passed++;
    else begin
      checks_failed++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int absd(input int a, input int b);
    return (a >= b) ? a - b : b - a;
  endfunction

  // Scoreboard entry for the rising edge being driven now.
  task automatic noteEdge(input int per);
    exp_t e;
    if (ref_ok) begin
      e.per = gap;
      e.stb = mprev_ok && (absd(gap, mprev) <= (gap >> 6));
      e.idx = 15;
      e.hit = 0;
      for (int i = 11; i >= 0; i--)
        if (absd(gap, note_tab[i]) <= (note_tab[i] >> 6)) begin
          e.idx = i;
          e.hit = 1;
        end
      exp_q.push_back(e);
      mprev    = gap;
      mprev_ok = 1;
    end
    ref_ok = 1;
    gap    = per;
  endtask

  task automatic applyStimulus(input int per, input int n);
    for (int e = 0; e < n; e++) begin
      tone_in = 1'b1;
      noteEdge(per);
      repeat (per / 2) tick();
      tone_in = 1'b0;
      repeat (per - per / 2) tick();
    end
  endtask

  // Narrow pulse followed by a 10-clk glitch high starting 20 clk after the edge.
  task automatic applyGlitch(input int per, input int n);
    for (int e = 0; e < n; e++) begin
      tone_in = 1'b1;
      noteEdge(per);
      repeat (10) tick();
      tone_in = 1'b0;
      repeat (10) tick();
      tone_in = 1'b1;
      repeat (10) tick();
      tone_in = 1'b0;
      repeat (per - 30) tick();
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_period"}, period, 0);
    checkOutput({tag, "_pv"}, period_valid, 0);
    checkOutput({tag, "_note_idx"}, note_idx, 15);
    checkOutput({tag, "_note_hit"}, note_hit, 0);
    checkOutput({tag, "_stable"}, stable, 0);
    checkOutput({tag, "_silent"}, silent, 1);
  endtask

  // Output monitor: pops the scoreboard on each period_valid and checks the note 12 clk later.
  int   note_wait = 0;
  exp_t pend;
  bit   pv_prev = 0;
  always @(negedge clk) begin
    if (note_wait > 0) begin
      note_wait--;
      if (note_wait == 0) begin
        checkOutput("note_idx", note_idx, pend.idx);
        checkOutput("note_hit", note_hit, pend.hit);
      end
    end
    if (period_valid) begin
      checkOutput("pv_single_cycle", pv_prev, 0);
      checkOutput("pv_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        pend = exp_q.pop_front();
        checkOutput("period", period, pend.per);
        checkOutput("stable", stable, pend.stb);
        note_wait = 12;
      end
    end
    pv_prev = period_valid;
  end

  initial begin
    tone_in = 1'b0;
    reset   = 1'b1;
    repeat (3) tick();
    checkReset("reset");
    reset = 1'b0;
    repeat (5) tick();
    checkReset("after_release");

    $display("[TB] 440 Hz tone");
    applyStimulus(P_A4, 4);
    checkOutput("silent_while_tone", silent, 0);

    $display("[TB] glitches inside 440 Hz tone");
    applyGlitch(P_A4, 3);
    applyStimulus(P_A4, 2);

    $display("[TB] tone stops, timeout");
    tone_in = 1'b1;
    noteEdge(P_A4);
    for (int i = 1; i <= TIMEOUT + 3; i++) begin
      tick();
      if (i == P_A4 / 2) tone_in = 1'b0;
      if (i == TIMEOUT + 2) checkOutput("silent_before_timeout", silent, 0);
    end
    checkOutput("silent_at_timeout", silent, 1);
    checkOutput("timeout_note_idx", note_idx, 15);
    checkOutput("timeout_note_hit", note_hit, 0);
    checkOutput("timeout_stable", stable, 0);
    checkOutput("timeout_period_hold", period, P_A4);
    checkOutput("timeout_drain", exp_q.size(), 0);
    ref_ok   = 0;
    mprev_ok = 0;
    repeat (50) tick();

    $display("[TB] 440 Hz then B4 then out-of-range period");
    applyStimulus(P_A4, 3);
    applyStimulus(P_B4, 3);
    applyStimulus(P_LOW, 3);
    checkOutput("low_silent", silent, 0);
    applyStimulus(P_A4, 2);

    $display("[TB] reset mid-period");
    tone_in = 1'b1;
    noteEdge(P_A4);
    repeat (P_A4 / 2) tick();
    tone_in = 1'b0;
    repeat (200) tick();
    @(posedge clk);
    #3 reset = 1'b1;
    #1 checkReset("async_reset");
    repeat (3) tick();
    reset    = 1'b0;
    ref_ok   = 0;
    mprev_ok = 0;
    checkOutput("reset_drain", exp_q.size(), 0);
    repeat (300) tick();
    applyStimulus(P_A4, 3);

    repeat (20) tick();
    checkOutput("final_drain", exp_q.size(), 0);
    checkOutput("final_note_pending", note_wait, 0);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
